// File: rtl/snes_link_pkg.sv
// Shared definitions for the host/cart command link: opcodes, tx FSM states,
// CRC constants and frame lengths.
package snes_link_pkg;

  localparam logic [7:0]  AWAITING_INIT_CMD = 8'h01;
  localparam logic [7:0]  INITIALIZING_RAM  = 8'h02;

  localparam logic [7:0]  CRC8_POLY  = 8'h07;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam int FRAME_LEN_CRC8  = 4;
  localparam int FRAME_LEN_CRC16 = 5;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_A1,
    SEND_A2,
    SEND_CRC,
    SEND_CRC_HI,
    SEND_CRC_LO,
    GAP
  } tx_state_e;

endpackage

// File: rtl/crc_byte_update.sv
// Combinational one-byte CRC step, MSB-first, no reflection. Width and
// polynomial are parameters so the receiver's checker can reuse it.
module crc_byte_update #(
  parameter int             W    = 8,
  parameter logic [W-1:0]   POLY = W'(8'h07)
) (
  input  logic [W-1:0] crc_in,
  input  logic [7:0]   data,
  output logic [W-1:0] crc_out
);

  logic [W-1:0] c;

  always_comb begin
    c = crc_in ^ (W'(data) << (W - 8));
    for (int i = 0; i < 8; i++) begin
      c = c[W-1] ? ((c << 1) ^ POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/cmd_frame_tx.sv
// Host-side command frame transmitter: cmd, arg1, arg2, then CRC-8 (or
// CRC-16/CCITT-FALSE high/low when CMD_FRAME_CRC16_EN is defined).
module cmd_frame_tx
  import snes_link_pkg::*;
#(
  parameter int         GAP_CYCLES = 0,
  parameter logic [7:0] CRC8_INIT  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd,
  input  logic [7:0] arg1,
  input  logic [7:0] arg2,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_sent,
  output logic       busy
);

`ifdef CMD_FRAME_CRC16_EN
  localparam int          CW   = 16;
  localparam logic [15:0] POLY = CRC16_POLY;
  localparam logic [15:0] SEED = CRC16_INIT;
`else
  localparam int          CW   = 8;
  localparam logic [7:0]  POLY = CRC8_POLY;
  localparam logic [7:0]  SEED = CRC8_INIT;
`endif

  // Skip GAP entirely when no idle cycles are requested.
  localparam tx_state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

  tx_state_e     state, state_d;
  logic [7:0]    cmd_q, a1_q, a2_q;
  logic [CW-1:0] crc_q, crc_next;
  logic [7:0]    gap_cnt;
  logic          live;
  logic          last_accept;
  logic          fold;
  logic          accept;
  logic          gap_done;

  crc_byte_update #(.W(CW), .POLY(POLY)) u_crc (
    .crc_in  (crc_q),
    .data    (tx_byte),
    .crc_out (crc_next)
  );

  // live keeps cmd_ready low until the first clock after reset release.
  assign cmd_ready = (state == IDLE) && live;
  assign busy      = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign gap_done  = (int'(gap_cnt) >= GAP_CYCLES - 1);

  always_comb begin
    state_d     = state;
    tx_valid    = 1'b0;
    tx_byte     = 8'h00;
    last_accept = 1'b0;
    fold        = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) state_d = SEND_CMD;
      end
      SEND_CMD: begin
        tx_valid = 1'b1;
        tx_byte  = cmd_q;
        fold     = 1'b1;
        if (tx_ready) state_d = SEND_A1;
      end
      SEND_A1: begin
        tx_valid = 1'b1;
        tx_byte  = a1_q;
        fold     = 1'b1;
        if (tx_ready) state_d = SEND_A2;
      end
      SEND_A2: begin
        tx_valid = 1'b1;
        tx_byte  = a2_q;
        fold     = 1'b1;
`ifdef CMD_FRAME_CRC16_EN
        if (tx_ready) state_d = SEND_CRC_HI;
`else
        if (tx_ready) state_d = SEND_CRC;
`endif
      end
`ifdef CMD_FRAME_CRC16_EN
      SEND_CRC_HI: begin
        tx_valid = 1'b1;
        tx_byte  = crc_q[15:8];
        if (tx_ready) state_d = SEND_CRC_LO;
      end
      SEND_CRC_LO: begin
        tx_valid = 1'b1;
        tx_byte  = crc_q[7:0];
        if (tx_ready) begin
          last_accept = 1'b1;
          state_d     = AFTER_FRAME;
        end
      end
`else
      SEND_CRC: begin
        tx_valid = 1'b1;
        tx_byte  = crc_q;
        if (tx_ready) begin
          last_accept = 1'b1;
          state_d     = AFTER_FRAME;
        end
      end
`endif
      GAP: begin
        if (gap_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      live       <= 1'b0;
      frame_sent <= 1'b0;
      cmd_q      <= 8'h00;
      a1_q       <= 8'h00;
      a2_q       <= 8'h00;
      crc_q      <= '0;
      gap_cnt    <= 8'h00;
    end else begin
      state      <= state_d;
      live       <= 1'b1;
      frame_sent <= last_accept;
      if (cmd_valid && cmd_ready) begin
        cmd_q <= cmd;
        a1_q  <= arg1;
        a2_q  <= arg2;
        crc_q <= SEED;
      end else if (accept && fold) begin
        crc_q <= crc_next;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'h00;
    end
  end

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Bench for cmd_frame_tx: one instance with a 4-cycle gap, one with no gap
// for back-to-back frames. Honours CMD_FRAME_CRC16_EN for the expected frame.
module tb_cmd_frame_tx;
  import snes_link_pkg::*;

  localparam int GAP_A = 4;
`ifdef CMD_FRAME_CRC16_EN
  localparam int FLEN = FRAME_LEN_CRC16;
`else
  localparam int FLEN = FRAME_LEN_CRC8;
`endif

  logic       clk;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, tx_valid, tx_ready, frame_sent, busy;
  logic [7:0] cmd, arg1, arg2, tx_byte;
  logic       cmd_valid_b, cmd_ready_b, tx_valid_b, tx_ready_b, frame_sent_b, busy_b;
  logic [7:0] cmd_b, arg1_b, arg2_b, tx_byte_b;

  logic [7:0] exp_q[$];
  int         num_checks = 0;
  int         num_fail   = 0;

  cmd_frame_tx #(.GAP_CYCLES(GAP_A)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .arg1(arg1), .arg2(arg2), .tx_byte(tx_byte), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .frame_sent(frame_sent), .busy(busy)
  );

  cmd_frame_tx #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .cmd(cmd_b), .arg1(arg1_b), .arg2(arg2_b), .tx_byte(tx_byte_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .frame_sent(frame_sent_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference CRCs computed one message bit at a time.
  function automatic logic [7:0] model_crc8(input logic [7:0] c, a1, a2);
    logic [7:0] msg[3];
    logic [7:0] r;
    logic       fb;
    msg[0] = c; msg[1] = a1; msg[2] = a2;
    r = 8'h00;
    for (int i = 0; i < 3; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = r[7] ^ msg[i][j];
        r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    return r;
  endfunction

  function automatic logic [15:0] model_crc16(input logic [7:0] c, a1, a2);
    logic [7:0]  msg[3];
    logic [15:0] r;
    logic        fb;
    msg[0] = c; msg[1] = a1; msg[2] = a2;
    r = 16'hFFFF;
    for (int i = 0; i < 3; i++)
      for (int j = 7; j >= 0; j--) begin
        fb = r[15] ^ msg[i][j];
        r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    return r;
  endfunction

  function automatic void push_frame(input logic [7:0] c, a1, a2);
`ifdef CMD_FRAME_CRC16_EN
    logic [15:0] r;
    r = model_crc16(c, a1, a2);
`endif
    exp_q.push_back(c);
    exp_q.push_back(a1);
    exp_q.push_back(a2);
`ifdef CMD_FRAME_CRC16_EN
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
`else
    exp_q.push_back(model_crc8(c, a1, a2));
`endif
  endfunction

  // Waits for cmd_ready, offers one command, and leaves garbage on the inputs.
  task automatic start_cmd(input logic [7:0] c, a1, a2, input bit keep, input bit use_model);
    int budget = 200;
    while (cmd_ready !== 1'b1 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    num_checks++;
    if (cmd_ready !== 1'b1) begin
      num_fail++;
      $display("FAIL start_cmd_ready: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd = c; arg1 = a1; arg2 = a2;
    if (use_model) push_frame(c, a1, a2);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
    cmd = 8'($urandom); arg1 = 8'($urandom); arg2 = 8'($urandom);
  endtask

  // mode 0: tx_ready always 1; 1: random; 2: 3-cycle stall on byte 1.
  task automatic drain(input int mode);
    int budget = 200;
    int idx    = 0;
    int stall  = 0;
    bit rdy;
    while (exp_q.size() > 0 && budget > 0) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: begin
          rdy = !(idx == 1 && stall < 3);
          if (!rdy) stall++;
        end
      endcase
      tx_ready = rdy;
      num_checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp_q[0]) begin
        num_fail++;
        $display("FAIL frame_byte[%0d]: tx_valid=%b tx_byte=%h required 1 %h", idx, tx_valid, tx_byte, exp_q[0]);
      end
      num_checks++;
      if (frame_sent !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
        num_fail++;
        $display("FAIL mid_frame_flags: frame_sent=%b cmd_ready=%b busy=%b required 0 0 1", frame_sent, cmd_ready, busy);
      end
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        idx++;
      end
      budget--;
    end
    tx_ready = 1'b0;
    num_checks++;
    if (idx != FLEN) begin
      num_fail++;
      $display("FAIL frame_length: got %0d bytes required %0d", idx, FLEN);
    end
    num_checks++;
    if (frame_sent !== 1'b1 || tx_valid !== 1'b0) begin
      num_fail++;
      $display("FAIL frame_sent_pulse: frame_sent=%b tx_valid=%b required 1 0", frame_sent, tx_valid);
    end
    @(negedge clk);
    num_checks++;
    if (frame_sent !== 1'b0) begin
      num_fail++;
      $display("FAIL frame_sent_width: frame_sent=%b required 0", frame_sent);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd = 8'h00; arg1 = 8'h00; arg2 = 8'h00; tx_ready = 1'b0;
    cmd_valid_b = 1'b0; cmd_b = 8'h00; arg1_b = 8'h00; arg2_b = 8'h00; tx_ready_b = 1'b1;
    repeat (3) @(negedge clk);
    num_checks++;
    if ({cmd_ready, tx_valid, tx_byte, frame_sent, busy} !== 12'h000) begin
      num_fail++;
      $display("FAIL reset_values: cmd_ready=%b tx_valid=%b tx_byte=%h frame_sent=%b busy=%b required all 0",
               cmd_ready, tx_valid, tx_byte, frame_sent, busy);
    end
    rst_n = 1'b1;
    #1;
    num_checks++;
    if (cmd_ready !== 1'b0) begin
      num_fail++;
      $display("FAIL reset_release_ready: cmd_ready=%b required 0 before first clock", cmd_ready);
    end
    @(negedge clk);
    num_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || cmd_ready_b !== 1'b1) begin
      num_fail++;
      $display("FAIL ready_after_reset: cmd_ready=%b busy=%b cmd_ready_b=%b required 1 0 1", cmd_ready, busy, cmd_ready_b);
    end
  endtask

  task automatic test_basic(input int mode);
`ifdef CMD_FRAME_CRC16_EN
    start_cmd(AWAITING_INIT_CMD, 8'h00, 8'h00, 1'b0, 1'b1);
`else
    exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h6B);
    start_cmd(AWAITING_INIT_CMD, 8'h00, 8'h00, 1'b0, 1'b0);
`endif
    drain(mode);
  endtask

  task automatic test_gap();
    logic [7:0] c2, a2_1, a2_2;
    c2 = INITIALIZING_RAM; a2_1 = 8'($urandom); a2_2 = 8'($urandom);
    start_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b1);
    cmd = c2; arg1 = a2_1; arg2 = a2_2;
    drain(0);
    for (int i = 1; i < GAP_A; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      num_checks++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1 || tx_valid !== 1'b0) begin
        num_fail++;
        $display("FAIL gap_cycle[%0d]: cmd_ready=%b busy=%b tx_valid=%b required 0 1 0", i, cmd_ready, busy, tx_valid);
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    num_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      num_fail++;
      $display("FAIL gap_end: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
    push_frame(c2, a2_1, a2_2);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain(1);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      start_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
      drain(1);
    end
  endtask

  task automatic test_mid_reset();
    start_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    num_checks++;
    if ({cmd_ready, tx_valid, tx_byte, frame_sent, busy} !== 12'h000) begin
      num_fail++;
      $display("FAIL async_reset: cmd_ready=%b tx_valid=%b tx_byte=%h frame_sent=%b busy=%b required all 0",
               cmd_ready, tx_valid, tx_byte, frame_sent, busy);
    end
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      num_checks++;
      if (frame_sent !== 1'b0 || tx_valid !== 1'b0) begin
        num_fail++;
        $display("FAIL reset_hold: frame_sent=%b tx_valid=%b required 0 0", frame_sent, tx_valid);
      end
    end
    tx_ready = 1'b0;
    rst_n = 1'b1;
    start_cmd(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b1);
    drain(0);
  endtask

`ifdef CMD_FRAME_CRC16_EN
  task automatic test_crc16();
    start_cmd(8'h31, 8'h32, 8'h33, 1'b0, 1'b1);
    drain(1);
  endtask
`endif

  // Second instance (no gap): next command accepted in the frame_sent cycle.
  task automatic test_back_to_back();
    logic [7:0] e1[$];
    logic [7:0] e2[$];
    logic [7:0] c2;
    exp_q.delete();
    push_frame(8'($urandom), 8'($urandom), 8'($urandom));
    e1 = exp_q;
    exp_q.delete();
    c2 = 8'($urandom);
    push_frame(c2, 8'($urandom), 8'($urandom));
    e2 = exp_q;
    exp_q.delete();
    tx_ready_b = 1'b1;
    cmd_valid_b = 1'b1; cmd_b = e1[0]; arg1_b = e1[1]; arg2_b = e1[2];
    @(negedge clk);
    cmd_b = e2[0]; arg1_b = e2[1]; arg2_b = e2[2];
    for (int k = 0; k < FLEN; k++) begin
      num_checks++;
      if (tx_valid_b !== 1'b1 || tx_byte_b !== e1[k] || cmd_ready_b !== 1'b0) begin
        num_fail++;
        $display("FAIL b2b_first[%0d]: tx_valid=%b tx_byte=%h cmd_ready=%b required 1 %h 0", k, tx_valid_b, tx_byte_b, cmd_ready_b, e1[k]);
      end
      @(negedge clk);
    end
    num_checks++;
    if (frame_sent_b !== 1'b1 || cmd_ready_b !== 1'b1 || tx_valid_b !== 1'b0) begin
      num_fail++;
      $display("FAIL b2b_sent_ready: frame_sent=%b cmd_ready=%b tx_valid=%b required 1 1 0", frame_sent_b, cmd_ready_b, tx_valid_b);
    end
    @(negedge clk);
    cmd_valid_b = 1'b0;
    for (int k = 0; k < FLEN; k++) begin
      num_checks++;
      if (tx_valid_b !== 1'b1 || tx_byte_b !== e2[k] || frame_sent_b !== 1'b0) begin
        num_fail++;
        $display("FAIL b2b_second[%0d]: tx_valid=%b tx_byte=%h frame_sent=%b required 1 %h 0", k, tx_valid_b, tx_byte_b, frame_sent_b, e2[k]);
      end
      @(negedge clk);
    end
    num_checks++;
    if (frame_sent_b !== 1'b1) begin
      num_fail++;
      $display("FAIL b2b_second_sent: frame_sent=%b required 1", frame_sent_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(2);
    test_gap();
    test_random(8);
    test_mid_reset();
`ifdef CMD_FRAME_CRC16_EN
    test_crc16();
`endif
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule

// File: doc/cmd_frame_tx.md
Name: cmd_frame_tx

Overview:
Host-side transmitter for the cart command link; the other end of the cart's command receiver/interpreter.
- Accepts one command (cmd, arg1, arg2) per handshake, appends a CRC-8, and emits the frame one byte at a time over a valid/ready byte stream.
- Sits between host-side control logic and the physical serializer (SPI/UART shim).
- Pulses frame_sent when the last byte of the frame has been accepted.

Parameters:
GAP_CYCLES, 0, idle cycles inserted after a frame's last byte is accepted before cmd_ready can rise again (0..255).
CRC8_INIT, 8'h00, CRC-8 seed loaded at the start of every frame.

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command word valid
cmd_ready  output  1  transmitter can accept a command
cmd  input  8  opcode byte (codes from shared package, e.g. 8'h01 AWAITING_INIT_CMD, 8'h02 INITIALIZING_RAM)
arg1  input  8  first argument byte
arg2  input  8  second argument byte
tx_byte  output  8  current frame byte
tx_valid  output  1  tx_byte valid
tx_ready  input  1  serializer accepts tx_byte this cycle
frame_sent  output  1  one-cycle pulse: final frame byte accepted
busy  output  1  high from command acceptance until the gap ends

Behaviour:
- Reset values: cmd_ready=0, tx_valid=0, tx_byte=8'h00, frame_sent=0, busy=0. FSM goes to IDLE. cmd_ready rises the first clock after rst_n deasserts.
- FSM states: IDLE, SEND_CMD, SEND_A1, SEND_A2, SEND_CRC (plus SEND_CRC_HI/LO with the optional feature), GAP.
- IDLE: cmd_ready=1. If cmd_valid&&cmd_ready:
  - latch cmd/arg1/arg2 into holding registers;
  - seed crc=CRC8_INIT;
  - go to SEND_CMD with tx_valid=1 and tx_byte=cmd on the next cycle.
  - Command acceptance to first tx_valid: 1 cycle.
- Byte rule: tx_byte and tx_valid stay stable while tx_valid&&!tx_ready. Each accept (tx_valid&&tx_ready) does three things:
  - folds the byte into crc;
  - advances the state;
  - presents the next byte in the following cycle, with no bubble.
- Order: cmd, arg1, arg2, crc8. The CRC byte is the CRC over the three preceding bytes.
- CRC-8: polynomial 0x07, MSB-first, no reflection, no final XOR.
- Last accept: frame_sent=1 for exactly one cycle, in the cycle after the accept. tx_valid drops in that same cycle.
- GAP: count GAP_CYCLES cycles, then return to IDLE. If GAP_CYCLES=0, go straight to IDLE, so cmd_ready=1 in the cycle frame_sent pulses.
- busy = (state != IDLE).
- cmd_ready=0 in every non-IDLE state. New commands are not queued; changes on cmd/arg inputs mid-frame have no effect.
- tx_ready high while tx_valid is low is ignored.
- Reset mid-frame: immediate return to reset values, no frame_sent, partial frame abandoned. The receiver resynchronises via CRC failure.

Optional Feature:
Macro CMD_FRAME_CRC16_EN.
- Defined: the CRC byte is replaced by two bytes of CRC-16/CCITT-FALSE:
  - polynomial 0x1021, seed 16'hFFFF, MSB-first;
  - sent high byte then low byte over cmd, arg1, arg2;
  - frame is 5 bytes; frame_sent follows acceptance of the low byte.
- Undefined: 4-byte frame with CRC-8 only; no CRC-16 logic is synthesised.

Decomposition:
- Package snes_link_pkg holds:
  - opcode constants (AWAITING_INIT_CMD=8'h01, INITIALIZING_RAM=8'h02);
  - the tx FSM state enum;
  - CRC8_POLY=8'h07, CRC16_POLY=16'h1021, CRC16_INIT=16'hFFFF;
  - FRAME_LEN_CRC8=4, FRAME_LEN_CRC16=5.
- One sub-module, crc_byte_update: combinational one-byte CRC step, parameterised on width/polynomial. Shared with the receiver's checker.

Test Plan:
- cmd=01, arg1=00, arg2=00, tx_ready tied 1 -> tx_byte sequence 01,00,00,6B on consecutive cycles; frame_sent pulses once in the cycle after the 6B accept.
- Same command, tx_ready low for 3 cycles during arg1 -> tx_byte holds 00 with tx_valid=1 throughout; final bytes unchanged (CRC 6B).
- cmd_valid held high with a new command during a frame -> cmd_ready=0 until the frame ends; the second frame starts only after frame_sent (+GAP_CYCLES=4 gap verified).
- rst_n asserted after arg1 is accepted -> outputs drop to reset values asynchronously; no frame_sent; next command sends a fresh frame with a correct CRC.
- With CMD_FRAME_CRC16_EN, cmd=31,32,33 -> bytes 31,32,33 followed by the CRC-16/CCITT-FALSE of "123", high byte first, checked against the reference model; frame length 5.
- Back-to-back commands with GAP_CYCLES=0 -> cmd_ready=1 in the frame_sent cycle; the next frame's cmd byte is presented one cycle after acceptance.
